// File: rtl/vhexacc_ctrl.sv
// Serial 16-bit hex accumulator (one shared nibble adder) plus a multiplexed 4-digit seven-segment scan.
// Add latency 4 cycles after the accepting edge; start is accepted only in IDLE and is never queued.
module vhexacc_ctrl #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_L,
  input  logic        start,
  input  logic [15:0] operand,
  input  logic        clear,
  output logic        busy,
  output logic        done,
  output logic [15:0] sum,
  output logic        oflow,
  output logic [6:0]  seg_L,
  output logic [3:0]  an_L
);

  typedef enum logic [2:0] {IDLE, ADD0, ADD1, ADD2, ADD3} state_t;

  localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);

  state_t      state_q, state_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] opnd_q, opnd_d;
  logic        carry_q, carry_d;
  logic        oflow_q, oflow_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [1:0]  nib_sel;
  logic [4:0]  nib_sum;
  logic [3:0]  disp_nib;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    carry_d = carry_q;
    oflow_d = oflow_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      ADD1:    nib_sel = 2'd1;
      ADD2:    nib_sel = 2'd2;
      ADD3:    nib_sel = 2'd3;
      default: nib_sel = 2'd0;
    endcase
    nib_sum = {1'b0, acc_q[{nib_sel, 2'b00} +: 4]} + {1'b0, opnd_q[{nib_sel, 2'b00} +: 4]}
            + {4'b0000, carry_q};

    // Clear overrides everything, including a start in the same cycle and any add in flight.
    if (clear) begin
      acc_d   = 16'h0000;
      oflow_d = 1'b0;
      state_d = IDLE;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            opnd_d  = operand;
            carry_d = 1'b0;
            busy_d  = 1'b1;
            state_d = ADD0;
          end
        end
        ADD0, ADD1, ADD2, ADD3: begin
          acc_d[{nib_sel, 2'b00} +: 4] = nib_sum[3:0];
          carry_d = nib_sum[4];
          case (state_q)
            ADD0:    state_d = ADD1;
            ADD1:    state_d = ADD2;
            ADD2:    state_d = ADD3;
            default: begin
              state_d = IDLE;
              oflow_d = oflow_q | nib_sum[4];
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          endcase
        end
        default: state_d = IDLE;
      endcase
    end

    if (cnt_q == SCAN_LAST) begin
      cnt_d = 16'h0000;
      idx_d = idx_q + 2'd1;
    end else begin
      cnt_d = cnt_q + 16'd1;
      idx_d = idx_q;
    end
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q <= IDLE;
      acc_q   <= 16'h0000;
      opnd_q  <= 16'h0000;
      carry_q <= 1'b0;
      oflow_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= 16'h0000;
      idx_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      carry_q <= carry_d;
      oflow_q <= oflow_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Decoder sees acc directly so the display tracks nibble writes in the same cycle.
  always_comb begin
    disp_nib = acc_q[{idx_q, 2'b00} +: 4];
    case (disp_nib)
      4'h0:    seg_L = 7'b100_0000;
      4'h1:    seg_L = 7'b111_1001;
      4'h2:    seg_L = 7'b010_0100;
      4'h3:    seg_L = 7'b011_0000;
      4'h4:    seg_L = 7'b001_1001;
      4'h5:    seg_L = 7'b001_0010;
      4'h6:    seg_L = 7'b000_0010;
      4'h7:    seg_L = 7'b111_1000;
      4'h8:    seg_L = 7'b000_0000;
      4'h9:    seg_L = 7'b001_0000;
      4'hA:    seg_L = 7'b000_1000;
      4'hB:    seg_L = 7'b000_0011;
      4'hC:    seg_L = 7'b100_0110;
      4'hD:    seg_L = 7'b010_0001;
      4'hE:    seg_L = 7'b000_0110;
      default: seg_L = 7'b000_1110;
    endcase
  end

  assign an_L  = ~(4'b0001 << idx_q);
  assign busy  = busy_q;
  assign done  = done_q;
  assign sum   = acc_q;
  assign oflow = oflow_q;

endmodule

// File: tb/tb_vhexacc_ctrl.sv
// Directed + random bench for vhexacc_ctrl; the accumulator is modelled as plain 17-bit addition
// and the display as a digit/segment lookup indexed by elapsed scan time.
module tb_vhexacc_ctrl;

  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        rst_L;
  logic        start;
  logic [15:0] operand;
  logic        clear;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        oflow;
  logic [6:0]  seg_L;
  logic [3:0]  an_L;

  int checks = 0;
  int failures = 0;

  logic [15:0] acc_m;
  logic        ofl_m;

  logic [6:0] seg_tab [16] = '{7'b100_0000, 7'b111_1001, 7'b010_0100, 7'b011_0000,
                               7'b001_1001, 7'b001_0010, 7'b000_0010, 7'b111_1000,
                               7'b000_0000, 7'b001_0000, 7'b000_1000, 7'b000_0011,
                               7'b100_0110, 7'b010_0001, 7'b000_0110, 7'b000_1110};
  logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  vhexacc_ctrl #(.SCAN_DIV(SD)) dut (
    .clk(clk), .rst_L(rst_L), .start(start), .operand(operand), .clear(clear),
    .busy(busy), .done(done), .sum(sum), .oflow(oflow), .seg_L(seg_L), .an_L(an_L)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_add(input logic [15:0] op);
    logic [16:0] r;
    r = {1'b0, acc_m} + {1'b0, op};
    acc_m = r[15:0];
    ofl_m = ofl_m | r[16];
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    acc_m = 16'h0000;
    ofl_m = 1'b0;
    chk("clear_sum", sum, 0);
    chk("clear_oflow", oflow, 0);
  endtask

  // One add with exact latency: busy after E0..E3, done and final result after E4.
  task automatic do_add(input logic [15:0] op);
    start = 1'b1;
    operand = op;
    tick();
    start = 1'b0;
    operand = 16'($urandom);
    chk("add_busy_e0", busy, 1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i < 4) begin
        chk("add_busy_mid", busy, 1);
        chk("add_nodone_mid", done, 0);
      end
    end
    model_add(op);
    chk("add_done", done, 1);
    chk("add_busy_end", busy, 0);
    chk("add_sum", sum, acc_m);
    chk("add_oflow", oflow, ofl_m);
    tick();
    chk("add_done_pulse", done, 0);
  endtask

  initial begin
    int ndone;
    logic [15:0] op1;
    bit found;
    logic [3:0] prev_an;

    rst_L = 1'b0;
    start = 1'b0;
    clear = 1'b0;
    operand = 16'h0000;
    acc_m = 16'h0000;
    ofl_m = 1'b0;
    #12;
    chk("rst_sum", sum, 0);
    chk("rst_oflow", oflow, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_an", an_L, 4'b1110);
    chk("rst_seg", seg_L, 7'b100_0000);
    tick();
    rst_L = 1'b1;
    tick();

    // Carry propagating across nibbles
    do_clear();
    do_add(16'h1234);
    do_add(16'h0FCD);
    chk("carry_sum_2201", sum, 16'h2201);
    chk("carry_oflow0", oflow, 0);

    // Overflow is sticky until clear
    do_clear();
    do_add(16'h0001);
    do_add(16'hFFFF);
    chk("ovf_sum", sum, 16'h0000);
    chk("ovf_set", oflow, 1);
    do_add(16'h0001);
    chk("ovf_sticky", oflow, 1);
    chk("ovf_sum1", sum, 16'h0001);
    do_clear();

    // Random accumulation against the arithmetic model
    for (int n = 0; n < 10; n++) do_add(16'($urandom));

    // Ignored start during ADD1, then back-to-back start in the done cycle
    ndone = 0;
    op1 = 16'($urandom);
    start = 1'b1; operand = op1;
    tick(); ndone += int'(done);
    start = 1'b0;
    tick(); ndone += int'(done);
    start = 1'b1; operand = 16'hFFFF;
    tick(); ndone += int'(done);
    start = 1'b0;
    chk("ign_busy", busy, 1);
    tick(); ndone += int'(done);
    tick(); ndone += int'(done);
    model_add(op1);
    chk("ign_done1", done, 1);
    chk("ign_sum1", sum, acc_m);
    start = 1'b1; operand = 16'h0010;
    tick(); ndone += int'(done);
    start = 1'b0;
    chk("b2b_busy", busy, 1);
    for (int i = 0; i < 4; i++) begin
      tick(); ndone += int'(done);
    end
    model_add(16'h0010);
    chk("b2b_done2_at5", done, 1);
    chk("b2b_sum", sum, acc_m);
    chk("b2b_oflow", oflow, ofl_m);
    for (int i = 0; i < 4; i++) begin
      tick(); ndone += int'(done);
    end
    chk("b2b_ndone", ndone, 2);

    // Clear together with start in IDLE: clear wins
    do_add(16'h0042);
    clear = 1'b1; start = 1'b1; operand = 16'h1111;
    tick();
    clear = 1'b0; start = 1'b0;
    acc_m = 16'h0000; ofl_m = 1'b0;
    chk("clrstart_busy", busy, 0);
    chk("clrstart_sum", sum, 0);

    // Clear during ADD2 aborts silently
    do_add(16'h3C3C);
    start = 1'b1; operand = 16'h0F0F;
    tick(); start = 1'b0;
    tick(); tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    acc_m = 16'h0000; ofl_m = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_sum", sum, 0);
    chk("abort_done", done, 0);
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      tick(); ndone += int'(done);
    end
    chk("abort_no_done", ndone, 0);

    // Asynchronous reset mid-ADD2
    do_add(16'h5A5A);
    start = 1'b1; operand = 16'hA5A5;
    tick(); start = 1'b0;
    tick(); tick();
    #2 rst_L = 1'b0;
    #1;
    acc_m = 16'h0000; ofl_m = 1'b0;
    chk("arst_sum", sum, 0);
    chk("arst_oflow", oflow, 0);
    chk("arst_busy", busy, 0);
    chk("arst_an", an_L, 4'b1110);
    chk("arst_seg", seg_L, 7'b100_0000);
    tick(); tick();
    rst_L = 1'b1;
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      tick(); ndone += int'(done);
    end
    chk("arst_no_done", ndone, 0);

    // Scan: align on the 0111 -> 1110 wrap, then walk two full frames
    do_add(16'hC0A9);
    found = 1'b0;
    prev_an = an_L;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (prev_an == 4'b0111 && an_L == 4'b1110) found = 1'b1;
      prev_an = an_L;
    end
    chk("scan_align", found, 1);
    for (int k = 0; k < 8 * SD; k++) begin
      chk("scan_an", an_L, an_tab[(k / SD) % 4]);
      chk("scan_seg", seg_L, seg_tab[acc_m[((k / SD) % 4) * 4 +: 4]]);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
